// File: rtl/a0_log_pkg.sv
// Shared types and constants for the a0 UART logger: transmitter states,
// 8N1 line levels and the ASCII helpers used by the optional hex format.
package a0_log_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam logic       START_LVL = 1'b0;
   localparam logic       STOP_LVL  = 1'b1;
   localparam int         DATA_BITS = 8;
   localparam logic [7:0] NEWLINE   = 8'h0A;

   // Uppercase ASCII for one hex digit: '0'..'9' are 0x30.., 'A'..'F' are 0x41..
   function automatic logic [7:0] hex_ascii(input logic [3:0] i_nib);
      return (i_nib < 4'd10) ? (8'h30 + {4'h0, i_nib}) : (8'h37 + {4'h0, i_nib});
   endfunction

endpackage

// File: rtl/a0_log_fifo.sv
// Synchronous capture FIFO for the a0 logger; a write into a full FIFO is
// accepted only when a read frees a slot in the same cycle.
module a0_log_fifo
   import a0_log_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_rd_en;
   logic             w_wr_en;

   assign empty   = (r_count == '0);
   assign full    = (r_count == CNT_W'(DEPTH));
   assign w_rd_en = pop && !empty;
   assign w_wr_en = push && (!full || w_rd_en);
   assign rdata   = r_mem[r_rd_ptr];
   assign count   = r_count;

   // NOTE: storage has no reset; contents are only visible through the pointers, which are reset.
   always_ff @(posedge CLK) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/a0_uart_logger.sv
// Captures every change of the a0 register and streams it out on an 8N1 UART.
// Define A0_LOG_HEX_EN to send ASCII hex plus newline instead of raw LSB-first bytes.
module a0_uart_logger
   import a0_log_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int CLK_DIV    = 868,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          CLK,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              a0,
   output logic                          uart_tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

`ifdef A0_LOG_HEX_EN
   localparam int FRAMES = WIDTH / 4 + 1;
`else
   localparam int FRAMES = WIDTH / 8;
`endif
   localparam int FIDX_W = $clog2(FRAMES + 1);
   localparam int BAUD_W = $clog2(CLK_DIV);
   localparam int BIT_W  = $clog2(DATA_BITS);

   tx_state_t         r_state;
   tx_state_t         w_next_state;
   logic [WIDTH-1:0]  r_last_val;
   logic [WIDTH-1:0]  r_shift;
   logic [WIDTH-1:0]  w_shift_next;
   logic [BAUD_W-1:0] r_baud;
   logic [BIT_W-1:0]  r_bit_idx;
   logic [FIDX_W-1:0] r_frame_idx;
   logic              r_overflow;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [WIDTH-1:0]  w_rdata;
   logic              w_bit_end;
   logic              w_last_bit;
   logic              w_last_frame;
   logic [7:0]        w_tx_byte;

   assign w_push = (a0 != r_last_val);

   a0_log_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (a0),
      .rdata (w_rdata),
      .count (fifo_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign w_bit_end    = (r_baud == BAUD_W'(CLK_DIV - 1));
   assign w_last_bit   = (r_bit_idx == BIT_W'(DATA_BITS - 1));
   assign w_last_frame = (r_frame_idx == FIDX_W'(FRAMES - 1));

`ifdef A0_LOG_HEX_EN
   // Most significant nibble goes first, the newline closes the word.
   assign w_tx_byte    = w_last_frame ? NEWLINE : hex_ascii(r_shift[WIDTH-1 -: 4]);
   assign w_shift_next = r_shift << 4;
`else
   assign w_tx_byte    = r_shift[7:0];
   assign w_shift_next = r_shift >> 8;
`endif

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = START;
            end
         end
         START: if (w_bit_end) w_next_state = DATA;
         DATA:  if (w_bit_end && w_last_bit) w_next_state = STOP;
         STOP:  if (w_bit_end) w_next_state = w_last_frame ? IDLE : START;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_last_val <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_last_val <= a0;
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_baud      <= '0;
         r_bit_idx   <= '0;
         r_frame_idx <= '0;
         r_shift     <= '0;
      end else begin
         r_baud <= (r_state == IDLE || w_bit_end) ? '0 : r_baud + BAUD_W'(1);
         if (w_pop) begin
            r_shift     <= w_rdata;
            r_frame_idx <= '0;
         end
         if (r_state == DATA && w_bit_end)
            r_bit_idx <= w_last_bit ? '0 : r_bit_idx + BIT_W'(1);
         // Frames of one word run back to back; the next word waits for an IDLE cycle.
         if (r_state == STOP && w_bit_end && !w_last_frame) begin
            r_frame_idx <= r_frame_idx + FIDX_W'(1);
            r_shift     <= w_shift_next;
         end
      end
   end

   // The line level is decoded from state, so reset returns it high without a clock.
   always_comb begin
      uart_tx = STOP_LVL;
      case (r_state)
         START:   uart_tx = START_LVL;
         DATA:    uart_tx = w_tx_byte[r_bit_idx];
         default: uart_tx = STOP_LVL;
      endcase
   end

   assign busy     = (r_state != IDLE) || (fifo_count != '0);
   assign overflow = r_overflow;

endmodule

// File: tb/tb_a0_uart_logger.sv
// Self-checking bench for a0_uart_logger: a UART monitor decodes the line and
// compares each byte against a scoreboard filled as a0 changes are driven.
module tb_a0_uart_logger;

   localparam int WIDTH      = 32;
   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef A0_LOG_HEX_EN
   localparam int FRAMES = WIDTH / 4 + 1;
`else
   localparam int FRAMES = WIDTH / 8;
`endif
   localparam int FRAME_CYC = 10 * CLK_DIV;
   localparam int HALF      = CLK_DIV / 2;

   logic             CLK = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] a0  = '0;
   logic             uart_tx;
   logic             busy;
   logic             overflow;
   logic [CNT_W-1:0] fifo_count;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cycle = 0;
   int   frames_seen = 0;
   logic [7:0] sb[$];
   int   frame_starts[$];

   a0_uart_logger #(
      .WIDTH      (WIDTH),
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .CLK        (CLK),
      .rst        (rst),
      .a0         (a0),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cycle++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected byte stream for one captured word.
   task automatic push_word(input logic [WIDTH-1:0] w);
`ifdef A0_LOG_HEX_EN
      for (int i = WIDTH / 4 - 1; i >= 0; i--) begin
         logic [3:0] n;
         n = w[i*4 +: 4];
         sb.push_back((n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n)));
      end
      sb.push_back(8'h0A);
`else
      for (int i = 0; i < WIDTH / 8; i++) sb.push_back(w[i*8 +: 8]);
`endif
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         @(negedge CLK);
         n++;
      end
      check("idle_timeout_busy", busy, 0);
   endtask

   // UART monitor: frame cycle 0 is the first negedge with the line low.
   int         mon_cyc = 0;
   bit         mon_active = 1'b0;
   logic [7:0] mon_byte = '0;

   always @(negedge CLK) begin
      if (rst) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (uart_tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cyc    = 0;
            frame_starts.push_back(cycle);
         end
      end else begin
         mon_cyc++;
         if (mon_cyc == HALF) begin
            check("start_bit", uart_tx, 0);
         end else if (mon_cyc > HALF && mon_cyc < 9 * CLK_DIV && (mon_cyc - HALF) % CLK_DIV == 0) begin
            mon_byte[(mon_cyc - HALF) / CLK_DIV - 1] = uart_tx;
         end else if (mon_cyc == 9 * CLK_DIV + HALF) begin
            check("stop_bit", uart_tx, 1);
            frames_seen++;
            if (sb.size() == 0) check("frame_expected", sb.size(), 1);
            else                check("frame_byte", mon_byte, sb.pop_front());
         end
         if (mon_cyc == FRAME_CYC - 1) mon_active = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int frames_before;

      // Reset state
      rst = 1'b1;
      a0  = '0;
      repeat (3) @(negedge CLK);
      check("rst_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_count", fifo_count, 0);

      // Idle line with a0 held at zero
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         check("idle_tx", uart_tx, 1);
         check("idle_busy", busy, 0);
         check("idle_count", fifo_count, 0);
      end

      // Raw word: start bit two cycles after the change, frames back to back
      frame_starts.delete();
      a0 = 32'h1234_5678;
      push_word(32'h1234_5678);
      @(negedge CLK);
      check("lat_c1_tx", uart_tx, 1);
      check("lat_c1_busy", busy, 1);
      @(negedge CLK);
      check("lat_c2_tx", uart_tx, 0);
      wait_idle(FRAMES * FRAME_CYC + 20);
      check("raw_sb_empty", sb.size(), 0);
      check("raw_frames", frame_starts.size(), FRAMES);
      for (int i = 1; i < frame_starts.size(); i++)
         check("raw_frame_len", frame_starts[i] - frame_starts[i-1], FRAME_CYC);
      check("raw_count_after", fifo_count, 0);

      // Overflow: 1..6 one per cycle; word 1 is popped as 2 arrives, 6 finds the FIFO full
      for (int v = 1; v <= 6; v++) begin
         @(negedge CLK);
         if (v == 6) check("ovf_before", overflow, 0);
         a0 = WIDTH'(v);
         if (v <= 5) push_word(WIDTH'(v));
      end
      @(negedge CLK);
      check("ovf_count_full", fifo_count, FIFO_DEPTH);
      check("ovf_flag", overflow, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check("ovf_count_hold", fifo_count, FIFO_DEPTH);
      end
      wait_idle(6 * FRAMES * FRAME_CYC);
      check("ovf_sb_empty", sb.size(), 0);
      check("ovf_sticky", overflow, 1);

      // Mid-frame reset during data bit 3, with a second word queued
      @(negedge CLK);
      a0 = 32'hA5A5_A5A5;
      push_word(32'hA5A5_A5A5);
      @(negedge CLK);
      a0 = 32'h0F0F_0F0F;
      push_word(32'h0F0F_0F0F);
      @(negedge CLK);
      check("mid_start", uart_tx, 0);
      check("mid_queued", fifo_count, 1);
      repeat (4 * CLK_DIV + 1) @(negedge CLK);
      check("mid_bit3_low", uart_tx, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", uart_tx, 1);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ovf_clear", overflow, 0);
      sb.delete();
      a0 = '0;
      repeat (2) @(negedge CLK);
      rst = 1'b0;
      frames_before = frames_seen;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         check("post_rst_tx", uart_tx, 1);
      end
      check("post_rst_frames", frames_seen - frames_before, 0);

      // Non-zero a0 is captured on the first cycle after reset
      rst = 1'b1;
      a0  = 32'h0000_0055;
      repeat (2) @(negedge CLK);
      rst = 1'b0;
      push_word(32'h0000_0055);
      @(negedge CLK);
      @(negedge CLK);
      check("first_cap_start", uart_tx, 0);
      wait_idle(FRAMES * FRAME_CYC + 20);
      check("first_cap_sb_empty", sb.size(), 0);

      // Same value written twice gives a single capture
      frames_before = frames_seen;
      @(negedge CLK);
      a0 = 32'h00C0_FFEE;
      push_word(32'h00C0_FFEE);
      @(negedge CLK);
      check("dup_count_1", fifo_count, 1);
      a0 = 32'h00C0_FFEE;
      @(negedge CLK);
      check("dup_count_0", fifo_count, 0);
      wait_idle(2 * FRAMES * FRAME_CYC);
      repeat (10) @(negedge CLK);
      check("dup_frames", frames_seen - frames_before, FRAMES);
      check("dup_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
